// File: rtl/ifu_fetch_queue_pkg.sv
// Shared fetch-stage constants and the {inst, pc} entry type buffered by the fetch queue.
// The PC register uses the same reset/base values.
package ifu_fetch_queue_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_VAL  = 32'h0000_3000;
    localparam int unsigned IM_AW_DEF    = 12;
    localparam int unsigned DEPTH_DEF    = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] inst;
        logic [31:0]        pc;
    } fq_entry_t;

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bus: PC register loop, instruction-memory read port, redirect and decode handshake.
// The master side is the fetch queue; the slave side is PC register, imem and decode.
interface ifu_fetch_queue_if #(
    parameter int unsigned IM_AW = 12,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      cur_pc;
    logic [31:0]      next_pc;
    logic [IM_AW-1:0] imem_addr;
    logic [31:0]      imem_rdata;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic [31:0]      inst_pc;
    logic [CNT_W-1:0] count;

    modport master (
        input  cur_pc, imem_rdata, redirect_valid, redirect_pc, inst_ready,
        output next_pc, imem_addr, inst_valid, inst, inst_pc, count
    );

    modport slave (
        output cur_pc, imem_rdata, redirect_valid, redirect_pc, inst_ready,
        input  next_pc, imem_addr, inst_valid, inst, inst_pc, count
    );

endinterface

// File: rtl/ifu_fetch_queue_fifo.sv
// DEPTH-entry {inst, pc} FIFO with naturally wrapping pointers and a flush that
// empties the queue by snapping the read pointer onto the write pointer.
module ifu_fetch_queue_fifo
    import ifu_fetch_queue_pkg::*;
#(
    parameter int unsigned  DEPTH = DEPTH_DEF,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = PW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  fq_entry_t        wdata_i,
    input  logic             pop_i,
    output fq_entry_t        head_o,
    output logic [CNT_W-1:0] count_o
);

    fq_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_en    = push_i && !flush_i && !reset_i;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Next-PC / fetch-buffer stage: issues one imem read per cycle while credit allows,
// buffers the returning {inst, pc} pairs and presents them to decode.
module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter logic [31:0] PC_RESET = PC_RESET_VAL,
    parameter logic [31:0] IM_BASE  = IM_BASE_VAL,
    parameter int unsigned IM_AW    = IM_AW_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    ifu_fetch_queue_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             req_v_q, req_v_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             issue, push, pop;
    logic [CNT_W-1:0] count;
    fq_entry_t        head, wdata;

    // Credit counts the in-flight word but not a same-cycle pop, so a push can never overflow.
    always_comb begin
        issue = !reset_i && !bus.redirect_valid &&
                (({1'b0, count} + (CNT_W+1)'(req_v_q)) < (CNT_W+1)'(DEPTH));
        bus.imem_addr = IM_AW'((bus.cur_pc - IM_BASE) >> 2);
        if (reset_i)                 bus.next_pc = PC_RESET;
        else if (bus.redirect_valid) bus.next_pc = pc_align(bus.redirect_pc);
        else if (issue)              bus.next_pc = bus.cur_pc + 32'd4;
        else                         bus.next_pc = bus.cur_pc;
    end

    always_comb begin
        req_v_d  = issue;
        req_pc_d = issue ? bus.cur_pc : req_pc_q;
        push     = req_v_q && !bus.redirect_valid && !reset_i;
        pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid && !reset_i;
        wdata    = '{inst: bus.imem_rdata, pc: req_pc_q};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
        end else begin
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
        end
    end

    ifu_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (bus.redirect_valid),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        bus.count      = count;
        bus.inst_valid = (count != '0);
        bus.inst       = head.inst;
        bus.inst_pc    = head.pc;
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: models the PC register and a 1-cycle imem returning the
// word index, and scoreboards every accepted instruction against the expected PC stream.
module tb_ifu_fetch_queue;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ifu_fetch_queue_if #(.IM_AW(12), .DEPTH(4)) bus ();

    ifu_fetch_queue #(
        .DEPTH    (4),
        .PC_RESET (32'h0000_3000),
        .IM_BASE  (32'h0000_3000),
        .IM_AW    (12)
    ) u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always @(posedge clk) begin
        bus.cur_pc     <= bus.next_pc;
        bus.imem_rdata <= {20'h0, bus.imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        if (!reset && !bus.redirect_valid && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", bus.inst_pc, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                logic [31:0] widx;
                e    = exp_q.pop_front();
                widx = (e - 32'h3000) >> 2;
                chk("sb_pc", bus.inst_pc, e);
                chk("sb_inst", bus.inst, {20'h0, widx[11:0]});
            end
        end
    end

    initial begin
        reset              = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // streaming from reset
        step(); step();
        chk("rst_cnt", 32'(bus.count), 32'd0);
        chk("rst_vld", 32'(bus.inst_valid), 32'd0);
        chk("rst_npc", bus.next_pc, 32'h3000);
        sb_restart(32'h3000);
        reset = 1'b0;
        #1;
        chk("p1_npc0", bus.next_pc, 32'h3004);
        chk("p1_addr", 32'(bus.imem_addr), 32'd0);
        step();
        chk("p1_vld1", 32'(bus.inst_valid), 32'd0);
        chk("p1_npc1", bus.next_pc, 32'h3008);
        step();
        chk("p1_vld2", 32'(bus.inst_valid), 32'd1);
        chk("p1_ipc2", bus.inst_pc, 32'h3000);
        step();
        chk("p1_ipc3", bus.inst_pc, 32'h3004);
        step();
        chk("p1_ipc4", bus.inst_pc, 32'h3008);
        chk("p1_npc4", bus.next_pc, 32'h3014);
        repeat (8) step();

        // backpressure from reset: fill, hold PC, then drain
        reset = 1'b1;
        bus.inst_ready = 1'b0;
        step(); step();
        sb_restart(32'h3000);
        reset = 1'b0;
        repeat (8) step();
        chk("p2_full", 32'(bus.count), 32'd4);
        chk("p2_hold", bus.next_pc, 32'h3010);
        chk("p2_head", bus.inst_pc, 32'h3000);
        step();
        chk("p2_hold2", bus.next_pc, 32'h3010);
        bus.inst_ready = 1'b1;
        repeat (6) step();
        chk("p2_steady", 32'(bus.count), 32'd2);

        // random backpressure across pointer wraps
        repeat (40) begin
            bus.inst_ready = 1'($urandom_range(0, 1));
            step();
            chk("p3_cnt_le", 32'(bus.count <= 3'd4), 32'd1);
        end

        // redirect with count=3 and a request in flight
        reset = 1'b1;
        bus.inst_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        repeat (4) step();
        chk("p4_pre", 32'(bus.count), 32'd3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3102;
        #1;
        chk("p4_npc", bus.next_pc, 32'h3100);
        sb_restart(32'h3100);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        chk("p4_cnt", 32'(bus.count), 32'd0);
        chk("p4_vld", 32'(bus.inst_valid), 32'd0);
        chk("p4_npc1", bus.next_pc, 32'h3104);
        step();
        chk("p4_vld2", 32'(bus.inst_valid), 32'd0);
        step();
        chk("p4_vld3", 32'(bus.inst_valid), 32'd1);
        chk("p4_ipc", bus.inst_pc, 32'h3100);
        chk("p4_inst", bus.inst, 32'h40);
        step();

        // reset mid-stream with count=2
        chk("p5_pre", 32'(bus.count), 32'd2);
        reset = 1'b1;
        #1;
        chk("p5_npc", bus.next_pc, 32'h3000);
        step();
        chk("p5_cnt", 32'(bus.count), 32'd0);
        chk("p5_vld", 32'(bus.inst_valid), 32'd0);
        sb_restart(32'h3000);
        bus.inst_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("p5_npc1", bus.next_pc, 32'h3004);
        step(); step();
        chk("p5_ipc", bus.inst_pc, 32'h3000);
        repeat (4) step();

        // reset and redirect together: reset wins
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3200;
        #1;
        chk("p6_npc", bus.next_pc, 32'h3000);
        step();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        sb_restart(32'h3000);
        #1;
        chk("p6_cnt", 32'(bus.count), 32'd0);
        chk("p6_npc1", bus.next_pc, 32'h3004);
        step(); step();
        chk("p6_ipc", bus.inst_pc, 32'h3000);
        repeat (6) step();

        bus.inst_ready = 1'b0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
